// File: rtl/writeback_cycle.sv
// writeback_cycle: final stage of the 19-bit CPU.
// Holds the M->W pipeline register and picks the value written back to the register file.
// It stalls upstream while a load waits on a slow data memory.
// It also counts retired instructions and records a sticky flag when a load times out.
module writeback_cycle #(
  parameter int WIDTH       = 19,
  parameter int RADDR_W     = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               validM,
  input  logic               regwriteM,
  input  logic               resultsrcM,
  input  logic [1:0]         jumpM,
  input  logic [RADDR_W-1:0] rdM,
  input  logic [WIDTH-1:0]   aluresultM,
  input  logic [WIDTH-1:0]   pcplus4M,
  input  logic               mem_rvalid,
  input  logic [WIDTH-1:0]   mem_rdata,
  input  logic               flushW,
  output logic               regwriteW,
  output logic [RADDR_W-1:0] rdW,
  output logic [WIDTH-1:0]   resultW,
  output logic               stall_req,
  output logic               mem_timeout,
  output logic [CNT_W-1:0]   retired_cnt
);

  localparam int TMR_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(MEM_TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT_MEM} stateT;

  stateT            state;
  logic [TMR_W-1:0] timer;

  logic             isLoad;
  logic             timerExpired;
  logic             doCapture;
  logic             doTimeout;
  logic             enterWait;
  logic             stallReq;
  logic [WIDTH-1:0] selResult;

  // Result select: a jump/link wins over a load, and a load wins over the ALU result.
  always_comb begin
    selResult = aluresultM;
    if (jumpM != 2'b00) begin
      selResult = pcplus4M;
    end else if (resultsrcM) begin
      selResult = mem_rdata;
    end
  end

  // Decide this cycle's action: capture, start a wait, time out, or bubble. A flush kills all of them.
  always_comb begin
    isLoad       = validM & resultsrcM & (jumpM == 2'b00);
    timerExpired = (timer == TIMER_LAST);
    doCapture    = 1'b0;
    doTimeout    = 1'b0;
    enterWait    = 1'b0;
    stallReq     = 1'b0;
    if (!flushW) begin
      case (state)
        IDLE: begin
          if (isLoad && !mem_rvalid) begin
            enterWait = 1'b1;
            stallReq  = 1'b1;
          end else if (validM) begin
            doCapture = 1'b1;
          end
        end
        WAIT_MEM: begin
          if (mem_rvalid) begin
            doCapture = 1'b1;
          end else if (timerExpired) begin
            doTimeout = 1'b1;
          end else begin
            stallReq = 1'b1;
          end
        end
      endcase
    end
  end

  // Upstream must never see a stall while the block is held in reset.
  assign stall_req = stallReq & rst;

  // Wait FSM, W-stage pipeline register, retire counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      timer       <= '0;
      regwriteW   <= 1'b0;
      rdW         <= '0;
      resultW     <= '0;
      mem_timeout <= 1'b0;
      retired_cnt <= '0;
    end else begin
      regwriteW <= 1'b0;
      if (doCapture) begin
        regwriteW <= regwriteM;
        rdW       <= rdM;
        resultW   <= selResult;
      end
      if (doCapture || doTimeout) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
      end
      if (doTimeout) begin
        mem_timeout <= 1'b1;
      end
      if (flushW) begin
        state <= IDLE;
        timer <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (enterWait) begin
              state <= WAIT_MEM;
              timer <= '0;
            end
          end
          WAIT_MEM: begin
            if (doCapture || doTimeout) begin
              state <= IDLE;
              timer <= '0;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
        endcase
      end
    end
  end

endmodule
